button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Conditions the raw watch push-buttons and the set-mode slide switch before the clock-offset adjust stage.
- Synchronises and debounces button2/button3 and emits one-cycle pulses on press, plus auto-repeat pulses while a button is held.
- Synchronises switch2.
- Outputs drive the offset stage's button2, button3 and switch2 inputs directly; each pulse advances an offset by exactly one count.

Parameters:
- DB_CYCLES, 50000: consecutive cycles a synchronised input must differ from its debounced state before that state flips.
- HOLD_CYCLES, 25000000: cycles from the press pulse to the first auto-repeat pulse.
- REPEAT_CYCLES, 5000000: cycles between subsequent auto-repeat pulses.
- CW, 25: width of the debounce and hold/repeat counters. Each *_CYCLES value must be ≤ 2^CW and ≥ 2.

Ports:
- userclock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- button2_raw  in  1  asynchronous raw button, high = pressed
- button3_raw  in  1  asynchronous raw button, high = pressed
- switch2_raw  in  1  asynchronous raw slide switch
- button2  out  1  one-cycle press/repeat pulse for button2
- button3  out  1  one-cycle press/repeat pulse for button3
- switch2  out  1  synchronised switch2 level

Behaviour:
- Clock and reset: one clock, userclock. reset is synchronous and active-high, sampled on the userclock rising edge.
- Reset values: all flops clear on reset. button2=0, button3=0, switch2=0; synchroniser flops 0; debounced states 0; counters 0; both FSMs in IDLE.
- Synchronisers: two-flop synchroniser per raw input. switch2 equals the second flop, with 2 cycles of latency and no debounce.
- Debounce (per button):
  - Holds a debounced state db and a counter c.
  - If sync != db: when c == DB_CYCLES-1, db flips and c clears; otherwise c increments.
  - If sync == db: c clears. Any glitch shorter than DB_CYCLES cycles is therefore rejected.
- FSM (per button, independent instances), states IDLE, HOLD, REPEAT, with timer t:
  - IDLE: if db==1, assert the pulse for one cycle, clear t, and go to HOLD.
  - HOLD: if db==0, go to IDLE. Else if t == HOLD_CYCLES-1, pulse, clear t, and go to REPEAT. Else t increments.
  - REPEAT: if db==0, go to IDLE. Else if t == REPEAT_CYCLES-1, pulse and clear t. Else t increments.
- Pulse output:
  - Registered, high for exactly one cycle per event.
  - Never high on two consecutive cycles.
  - Release (db falling) produces no pulse.
- Press latency: if edge k is the first edge at which the synchroniser's first flop samples raw=1 (and the raw level stays stable), the pulse is high in the cycle after edge k+DB_CYCLES+2.
- Simultaneous events:
  - Buttons are fully independent; both pulses may assert in the same cycle. Priority is the downstream stage's concern.
  - In HOLD or REPEAT, a release on the same cycle as a timer expiry takes the release: go to IDLE, no pulse.
- Reset mid-operation:
  - All state returns to reset values, and no pulse is asserted in the cycle after the reset edge.
  - A button still held through reset must re-debounce from 0 (DB_CYCLES+2 cycles) and then produce a fresh press pulse.
- Counter widths: counters saturate nowhere. Each is cleared at its terminal value, so no wrap-around occurs for legal parameters.

Test Plan:
- Use DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: reset 2 cycles, raise button2_raw and hold it for 8 cycles, then drop it. Expect exactly one button2 pulse, 6 cycles after the first sampling edge; button3 stays 0 throughout.
- Glitch rejection: button3_raw high for 3 cycles, then low. Expect button3 to stay 0 and the debounced state never to flip. A 4-cycle-plus-sync pulse of button3_raw produces exactly one pulse.
- Auto-repeat: hold button2_raw for 40 cycles. Expect a press pulse at P, a first repeat at P+10, and further repeats at P+13, P+16, and so on every 3 cycles until db falls. No pulse on release.
- Simultaneous buttons: raise button2_raw and button3_raw on the same edge. Expect both pulses in the same cycle and identical repeat timing for both.
- Reset mid-hold: hold button2_raw and assert reset during REPEAT. Expect all outputs 0 the next cycle, then a single fresh press pulse 6 cycles after reset deasserts, while the button is still held.
- switch2: toggle switch2_raw. Expect switch2 to follow with 2 cycles of latency; a 1-cycle glitch passes through delayed by 2 cycles.

Source files
------------

// File: rtl/button_conditioner.sv
// Watch push-button front end: two-flop synchronisers, per-button debounce and a
// press / auto-repeat pulse FSM for button2 and button3, plus a synchronised switch2 level.
module button_conditioner #(
  parameter int DB_CYCLES     = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CW            = 25
) (
  input  logic userclock,
  input  logic reset,
  input  logic button2_raw,
  input  logic button3_raw,
  input  logic switch2_raw,
  output logic button2,
  output logic button3,
  output logic switch2
);

  // Terminal counter values; each counter clears here, so it never wraps.
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  if (DB_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_min
    $error("button_conditioner: every *_CYCLES parameter must be at least 2");
  end
  if (longint'(DB_CYCLES) > (longint'(1) << CW) ||
      longint'(HOLD_CYCLES) > (longint'(1) << CW) ||
      longint'(REPEAT_CYCLES) > (longint'(1) << CW)) begin : g_bad_max
    $error("button_conditioner: a *_CYCLES parameter does not fit in CW bits");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } fsm_state_e;

  // FSM state and its timer travel together so a checker can bind to one struct.
  typedef struct packed {
    fsm_state_e    state;
    logic [CW-1:0] t;
  } fsm_t;

  logic [1:0] raw_vec;
  assign raw_vec = {button3_raw, button2_raw};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0]    sync_q;
    logic          db_q;
    logic [CW-1:0] c_q;
    fsm_t          fsm_q;
    fsm_t          fsm_d;
    logic          pulse_q;
    logic          pulse_d;

    always_ff @(posedge userclock) begin
      if (reset) begin
        sync_q <= 2'b00;
      end else begin
        sync_q <= {sync_q[0], raw_vec[i]};
      end
    end

    // db only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge userclock) begin
      if (reset) begin
        db_q <= 1'b0;
        c_q  <= '0;
      end else if (sync_q[1] != db_q) begin
        if (c_q == DB_LAST) begin
          db_q <= ~db_q;
          c_q  <= '0;
        end else begin
          c_q <= c_q + CW'(1);
        end
      end else begin
        c_q <= '0;
      end
    end

    always_ff @(posedge userclock) begin
      if (reset) begin
        fsm_q   <= '{state: IDLE, t: '0};
        pulse_q <= 1'b0;
      end else begin
        fsm_q   <= fsm_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      fsm_d = fsm_q;
      case (fsm_q.state)
        IDLE: begin
          if (db_q) fsm_d = '{state: HOLD, t: '0};
        end
        HOLD: begin
          if (!db_q)                    fsm_d = '{state: IDLE, t: '0};
          else if (fsm_q.t == HOLD_LAST) fsm_d = '{state: REPEAT, t: '0};
          else                          fsm_d.t = fsm_q.t + CW'(1);
        end
        REPEAT: begin
          if (!db_q)                      fsm_d = '{state: IDLE, t: '0};
          else if (fsm_q.t == REPEAT_LAST) fsm_d.t = '0;
          else                            fsm_d.t = fsm_q.t + CW'(1);
        end
        default: fsm_d = '{state: IDLE, t: '0};
      endcase
    end

    // A release wins over a coinciding timer expiry, so db gates every pulse.
    always_comb begin
      pulse_d = 1'b0;
      case (fsm_q.state)
        IDLE:    pulse_d = db_q;
        HOLD:    pulse_d = db_q && (fsm_q.t == HOLD_LAST);
        REPEAT:  pulse_d = db_q && (fsm_q.t == REPEAT_LAST);
        default: pulse_d = 1'b0;
      endcase
    end
  end

  logic [1:0] sw_sync_q;

  always_ff @(posedge userclock) begin
    if (reset) begin
      sw_sync_q <= 2'b00;
    end else begin
      sw_sync_q <= {sw_sync_q[0], switch2_raw};
    end
  end

  assign button2 = g_btn[0].pulse_q;
  assign button3 = g_btn[1].pulse_q;
  assign switch2 = sw_sync_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random toggling, every cycle
// compared against a run-length / hold-time reference model.
module tb_button_conditioner;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic userclock = 1'b0;
  logic reset = 1'b1;
  logic button2_raw = 1'b0;
  logic button3_raw = 1'b0;
  logic switch2_raw = 1'b0;
  logic button2;
  logic button3;
  logic switch2;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int seen2 = 0;
  int seen3 = 0;

  // Reference model: sync pipe, run length of the synchronised level, debounced
  // level and how many consecutive cycles the debounced level has been high.
  bit m_s1[3];
  bit m_s2[3];
  bit m_last[2];
  int m_run[2];
  bit m_db[2];
  int m_held[2];
  bit m_pulse[2];

  button_conditioner #(
    .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CW(25)
  ) dut (
    .userclock(userclock), .reset(reset),
    .button2_raw(button2_raw), .button3_raw(button3_raw), .switch2_raw(switch2_raw),
    .button2(button2), .button3(button3), .switch2(switch2)
  );

  always #5 userclock = ~userclock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic model_edge(input bit rst, input bit r0, input bit r1, input bit r2);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_s1[k] = 1'b0;
        m_s2[k] = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
        m_last[b] = 1'b0; m_run[b] = 0; m_db[b] = 1'b0;
        m_held[b] = 0; m_pulse[b] = 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        // Pulse on the first high cycle, then at HOLD, HOLD+REP, HOLD+2*REP, ...
        m_pulse[b] = m_db[b] && (m_held[b] == 0 ||
                     (m_held[b] >= HOLD && (m_held[b] - HOLD) % REP == 0));
        m_held[b] = m_db[b] ? m_held[b] + 1 : 0;
        if (m_s2[b] == m_last[b]) m_run[b]++;
        else m_run[b] = 1;
        m_last[b] = m_s2[b];
        if (m_s2[b] != m_db[b] && m_run[b] >= DB) m_db[b] = m_s2[b];
      end
      for (int k = 0; k < 3; k++) m_s2[k] = m_s1[k];
      m_s1[0] = r0;
      m_s1[1] = r1;
      m_s1[2] = r2;
    end
  endtask

  task automatic step(input bit rst, input bit b2, input bit b3, input bit sw);
    reset = rst;
    button2_raw = b2;
    button3_raw = b3;
    switch2_raw = sw;
    @(posedge userclock);
    model_edge(rst, b2, b3, sw);
    cycle++;
    @(negedge userclock);
    check_eq("button2", button2, m_pulse[0]);
    check_eq("button3", button3, m_pulse[1]);
    check_eq("switch2", switch2, m_s2[2]);
    if (button2 === 1'b1) seen2++;
    if (button3 === 1'b1) seen3++;
  endtask

  initial begin
    bit r2, r3, rs;
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("reset_button2", button2, 0);
    check_eq("reset_button3", button3, 0);
    check_eq("reset_switch2", switch2, 0);

    seen2 = 0; seen3 = 0;
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("clean_press_count2", seen2, 1);
    check_eq("clean_press_count3", seen3, 0);

    seen3 = 0;
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("glitch_count3", seen3, 0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("short_press_count3", seen3, 1);

    seen2 = 0;
    repeat (40) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("repeat_count2", seen2, 11);

    seen2 = 0; seen3 = 0;
    repeat (30) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("simul_count2", seen2, 8);
    check_eq("simul_count3", seen3, 8);

    repeat (25) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("midhold_reset_button2", button2, 0);
    seen2 = 0;
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("after_reset_count2", seen2, 5);

    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);

    r2 = 1'b0; r3 = 1'b0; rs = 1'b0;
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 9) == 0) r2 = ~r2;
      if ($urandom_range(0, 7) == 0) r3 = ~r3;
      if ($urandom_range(0, 4) == 0) rs = ~rs;
      step(($urandom_range(0, 299) == 0), r2, r3, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
